// File: rtl/alu_unit_pkg.sv
// Shared definitions for the ALU issue unit: operation encodings, bus widths
// and the layout of one buffered CDB result.
package alu_unit_pkg;

   localparam int DataWidth = 32;
   localparam int OpIdBus   = 6;
   localparam int ROBIDBus  = 4;
   localparam int ImmWidth  = 32;

   localparam logic True  = 1'b1;
   localparam logic False = 1'b0;

   localparam logic [OpIdBus-1:0] LUI   = 6'd1,  AUIPC = 6'd2,  JAL   = 6'd3,  JALR  = 6'd4;
   localparam logic [OpIdBus-1:0] BEQ   = 6'd5,  BNE   = 6'd6,  BLT   = 6'd7,  BGE   = 6'd8;
   localparam logic [OpIdBus-1:0] BLTU  = 6'd9,  BGEU  = 6'd10;
   localparam logic [OpIdBus-1:0] LB    = 6'd11, LH    = 6'd12, LW    = 6'd13, LBU   = 6'd14;
   localparam logic [OpIdBus-1:0] LHU   = 6'd15, SB    = 6'd16, SH    = 6'd17, SW    = 6'd18;
   localparam logic [OpIdBus-1:0] ADDI  = 6'd19, SLTI  = 6'd20, SLTIU = 6'd21, XORI  = 6'd22;
   localparam logic [OpIdBus-1:0] ORI   = 6'd23, ANDI  = 6'd24, SLLI  = 6'd25, SRLI  = 6'd26;
   localparam logic [OpIdBus-1:0] SRAI  = 6'd27, ADD   = 6'd28, SUB   = 6'd29, SLL   = 6'd30;
   localparam logic [OpIdBus-1:0] SLT   = 6'd31, SLTU  = 6'd32, XOR   = 6'd33, SRL   = 6'd34;
   localparam logic [OpIdBus-1:0] SRA   = 6'd35, OR    = 6'd36, AND   = 6'd37;

   typedef struct packed {
      logic [ROBIDBus-1:0]  rob_id;
      logic [DataWidth-1:0] value;
      logic                 is_jump;
      logic [DataWidth-1:0] target;
   } cdb_entry_t;

endpackage

// File: rtl/alu_unit_core.sv
// Combinational ALU datapath: result value, jump decision and next-PC target
// for one issued instruction.
module alu_core
   import alu_unit_pkg::*;
(
   input  logic [OpIdBus-1:0]   op,
   input  logic [DataWidth-1:0] pc,
   input  logic [DataWidth-1:0] rs1,
   input  logic [DataWidth-1:0] rs2,
   input  logic [ImmWidth-1:0]  imm,
   output logic [DataWidth-1:0] value,
   output logic                 is_jump,
   output logic [DataWidth-1:0] target
);

   logic [DataWidth-1:0]        op2, pc_next, pc_rel;
   logic signed [DataWidth-1:0] rs1_s, rs2_s, op2_s;
   logic [4:0]                  shamt;
   logic                        taken;

   // Immediate-form opcodes occupy one contiguous block of encodings.
   assign op2     = (op >= ADDI && op <= SRAI) ? imm : rs2;
   assign rs1_s   = rs1;
   assign rs2_s   = rs2;
   assign op2_s   = op2;
   assign shamt   = op2[4:0];
   assign pc_next = pc + DataWidth'(4);
   assign pc_rel  = pc + imm;

   always_comb begin
      value   = '0;
      is_jump = False;
      target  = pc_next;
      taken   = False;
      case (op)
         LUI:        value = imm;
         AUIPC:      value = pc_rel;
         JAL: begin
            value   = pc_next;
            is_jump = True;
            target  = pc_rel;
         end
         JALR: begin
            value   = pc_next;
            is_jump = True;
            target  = (rs1 + imm) & ~DataWidth'(1);
         end
         BEQ:        taken = (rs1 == rs2);
         BNE:        taken = (rs1 != rs2);
         BLT:        taken = (rs1_s < rs2_s);
         BGE:        taken = (rs1_s >= rs2_s);
         BLTU:       taken = (rs1 < rs2);
         BGEU:       taken = (rs1 >= rs2);
         ADD, ADDI:  value = rs1 + op2;
         SUB:        value = rs1 - rs2;
         SLL, SLLI:  value = rs1 << shamt;
         SRL, SRLI:  value = rs1 >> shamt;
         SRA, SRAI:  value = rs1_s >>> shamt;
         SLT, SLTI:  value = DataWidth'(rs1_s < op2_s);
         SLTU, SLTIU: value = DataWidth'(rs1 < op2);
         XOR, XORI:  value = rs1 ^ op2;
         OR, ORI:    value = rs1 | op2;
         AND, ANDI:  value = rs1 & op2;
         default:    value = '0;
      endcase
      if (op >= BEQ && op <= BGEU) begin
         is_jump = taken;
         target  = taken ? pc_rel : pc_next;
      end
   end

endmodule

// File: rtl/alu_unit.sv
// ALU issue unit: accepts instructions from the reservation station and
// buffers up to two results for the common data bus.
module alu_unit
   import alu_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 RS_enable,
   input  logic [OpIdBus-1:0]   RS_OP_ID,
   input  logic [DataWidth-1:0] RS_pc,
   input  logic [DataWidth-1:0] RS_reg_rs1,
   input  logic [DataWidth-1:0] RS_reg_rs2,
   input  logic [ImmWidth-1:0]  RS_imm,
   input  logic [ROBIDBus-1:0]  RS_ROB_id,
   output logic                 ALU_ready,
   input  logic                 ROB_flush,
   input  logic                 CDB_grant,
   output logic                 CDB_valid,
   output logic [ROBIDBus-1:0]  CDB_ROB_id,
   output logic [DataWidth-1:0] CDB_value,
   output logic                 CDB_is_jump,
   output logic [DataWidth-1:0] CDB_target_pc
);

   logic [1:0]           count;
   logic                 wr_ptr, rd_ptr;
   logic                 push, pop;
   cdb_entry_t           fifo_mem [2];
   cdb_entry_t           issue_entry, head;
   logic [DataWidth-1:0] core_value, core_target;
   logic                 core_is_jump;

   alu_core u_core (
      .op      (RS_OP_ID),
      .pc      (RS_pc),
      .rs1     (RS_reg_rs1),
      .rs2     (RS_reg_rs2),
      .imm     (RS_imm),
      .value   (core_value),
      .is_jump (core_is_jump),
      .target  (core_target)
   );

   assign issue_entry = '{rob_id: RS_ROB_id, value: core_value,
                          is_jump: core_is_jump, target: core_target};

   // rst is folded in so the ready/valid outputs drop the instant reset asserts.
   assign ALU_ready = rst && rdy && (count < 2'd2);
   assign CDB_valid = (count != 2'd0);
   assign push      = RS_enable && ALU_ready && !ROB_flush;
   assign pop       = rdy && CDB_valid && CDB_grant && !ROB_flush;

   // Outputs are gated by valid so an empty or reset FIFO presents all zeros.
   assign head          = fifo_mem[rd_ptr];
   assign CDB_ROB_id    = CDB_valid ? head.rob_id  : '0;
   assign CDB_value     = CDB_valid ? head.value   : '0;
   assign CDB_is_jump   = CDB_valid ? head.is_jump : False;
   assign CDB_target_pc = CDB_valid ? head.target  : '0;

   // A flush discards buffered results even while rdy is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (ROB_flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= issue_entry;
   end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed scenarios plus randomized traffic
// checked against a behavioural RISC-V ALU model.
module tb_alu_unit;
   import alu_unit_pkg::*;

   logic        clk, rst, rdy, RS_enable, ALU_ready, ROB_flush, CDB_grant;
   logic [5:0]  RS_OP_ID;
   logic [31:0] RS_pc, RS_reg_rs1, RS_reg_rs2, RS_imm;
   logic [3:0]  RS_ROB_id;
   logic        CDB_valid, CDB_is_jump;
   logic [3:0]  CDB_ROB_id;
   logic [31:0] CDB_value, CDB_target_pc;

   typedef struct packed {
      bit [3:0]  rob;
      bit [31:0] value;
      bit        jmp;
      bit [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   head_present;

   alu_unit dut (
      .clk(clk), .rst(rst), .rdy(rdy), .RS_enable(RS_enable), .RS_OP_ID(RS_OP_ID),
      .RS_pc(RS_pc), .RS_reg_rs1(RS_reg_rs1), .RS_reg_rs2(RS_reg_rs2), .RS_imm(RS_imm),
      .RS_ROB_id(RS_ROB_id), .ALU_ready(ALU_ready), .ROB_flush(ROB_flush),
      .CDB_grant(CDB_grant), .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id),
      .CDB_value(CDB_value), .CDB_is_jump(CDB_is_jump), .CDB_target_pc(CDB_target_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic bit signed_lt(input bit [31:0] a, input bit [31:0] b);
      return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
   endfunction

   function automatic exp_t ref_alu(input bit [5:0] op, input bit [31:0] pc, a, b, imm,
                                    input bit [3:0] rob);
      exp_t      e;
      bit [31:0] s2;
      bit [4:0]  sh;
      bit        tk;
      s2 = (op >= ADDI && op <= SRAI) ? imm : b;
      sh = s2[4:0];
      tk = 1'b0;
      e.rob = rob; e.value = 0; e.jmp = 0; e.tgt = pc + 4;
      case (op)
         LUI:   e.value = imm;
         AUIPC: e.value = pc + imm;
         JAL:   begin e.value = pc + 4; e.jmp = 1; e.tgt = pc + imm; end
         JALR:  begin e.value = pc + 4; e.jmp = 1; e.tgt = (a + imm) & 32'hFFFF_FFFE; end
         BEQ:   tk = (a == b);
         BNE:   tk = (a != b);
         BLT:   tk = signed_lt(a, b);
         BGE:   tk = !signed_lt(a, b);
         BLTU:  tk = (a < b);
         BGEU:  tk = !(a < b);
         ADD, ADDI:   e.value = a + s2;
         SUB:         e.value = a - b;
         SLL, SLLI:   e.value = a << sh;
         SRL, SRLI:   e.value = a >> sh;
         SRA, SRAI:   e.value = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         SLT, SLTI:   e.value = {31'd0, signed_lt(a, s2)};
         SLTU, SLTIU: e.value = {31'd0, a < s2};
         XOR, XORI:   e.value = a ^ s2;
         OR, ORI:     e.value = a | s2;
         AND, ANDI:   e.value = a & s2;
         default: ;
      endcase
      if (op >= BEQ && op <= BGEU) begin
         e.jmp = tk;
         e.tgt = tk ? pc + imm : pc + 4;
      end
      return e;
   endfunction

   // Drive one cycle of stimulus (called just after a falling edge); the
   // expected result of an accepted issue goes straight into the scoreboard.
   task automatic drive(input bit en, input bit [5:0] op, input bit [31:0] pc, a, b, imm,
                        input bit [3:0] rob, input bit grant, r, fl, output bit acc);
      rst = 1'b1; RS_enable = en; RS_OP_ID = op; RS_pc = pc; RS_reg_rs1 = a;
      RS_reg_rs2 = b; RS_imm = imm; RS_ROB_id = rob; CDB_grant = grant;
      rdy = r; ROB_flush = fl;
      #1;
      acc = en && ALU_ready && !fl;
      if (acc) exp_q.push_back(ref_alu(op, pc, a, b, imm, rob));
   endtask

   task automatic issue(input bit [5:0] op, input bit [31:0] pc, a, b, imm,
                        input bit [3:0] rob, input bit grant, output bit acc);
      @(negedge clk);
      drive(1'b1, op, pc, a, b, imm, rob, grant, 1'b1, 1'b0, acc);
   endtask

   task automatic idle(input bit grant);
      bit acc;
      @(negedge clk);
      drive(1'b0, 6'd0, 0, 0, 0, 0, 4'd0, grant, 1'b1, 1'b0, acc);
   endtask

   // Monitor: retire the head when the DUT pops it, then compare the bus.
   initial begin
      exp_t e;
      head_present = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            exp_q.delete();
            head_present = 1'b0;
            chk("reset_valid", CDB_valid, 0);
            chk("reset_ready", ALU_ready, 0);
         end else begin
            if (ROB_flush) exp_q.delete();
            else if (head_present && CDB_grant && rdy && exp_q.size() > 0)
               void'(exp_q.pop_front());
            chk("cdb_valid", CDB_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               chk("cdb_head", {CDB_ROB_id, CDB_value, CDB_is_jump, CDB_target_pc},
                   {e.rob, e.value, e.jmp, e.tgt});
            end
            chk("alu_ready", ALU_ready, rdy && exp_q.size() < 2);
            head_present = (exp_q.size() != 0);
         end
      end
   end

   initial begin
      bit        acc, acc3, have;
      bit [5:0]  op;
      bit [31:0] pc, a, b, imm;
      bit [3:0]  rob;
      bit        en, grant, r, fl;

      rst = 1'b0; rdy = 1'b1; RS_enable = 0; RS_OP_ID = 0; RS_pc = 0; RS_reg_rs1 = 0;
      RS_reg_rs2 = 0; RS_imm = 0; RS_ROB_id = 0; ROB_flush = 0; CDB_grant = 0;
      #2;
      chk("reset_outputs", {CDB_valid, CDB_ROB_id, CDB_value, CDB_is_jump, CDB_target_pc, ALU_ready}, 0);

      // First issue coincides with reset release.
      issue(ADD, 32'h0, 32'd5, 32'd7, 32'd0, 4'd3, 1'b1, acc);
      chk("first_accept", acc, 1);
      @(posedge clk); #2;
      chk("add_valid", CDB_valid, 1);
      chk("add_result", {CDB_ROB_id, CDB_value}, {4'd3, 32'd12});
      idle(1'b1);
      @(posedge clk); #2;
      chk("add_drained", CDB_valid, 0);

      issue(BLT, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd1, 1'b1, acc);
      @(posedge clk); #2;
      chk("blt_taken", {CDB_is_jump, CDB_target_pc}, {1'b1, 32'h120});
      issue(BLTU, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd2, 1'b1, acc);
      @(posedge clk); #2;
      chk("bltu_not_taken", {CDB_is_jump, CDB_target_pc}, {1'b0, 32'h104});

      issue(JALR, 32'h40, 32'h1003, 32'd0, 32'd4, 4'd4, 1'b1, acc);
      @(posedge clk); #2;
      chk("jalr", {CDB_value, CDB_is_jump, CDB_target_pc}, {32'h44, 1'b1, 32'h1006});
      issue(SRA, 32'h0, 32'h8000_0000, 32'h21, 32'd0, 4'd5, 1'b1, acc);
      @(posedge clk); #2;
      chk("sra", CDB_value, 32'hC000_0000);
      idle(1'b1);
      idle(1'b1);

      // Back-pressure: third issue is held until the grant drains a slot.
      issue(ADD, 32'h10, 32'd1, 32'd1, 32'd0, 4'd6, 1'b0, acc);
      issue(SUB, 32'h14, 32'd9, 32'd4, 32'd0, 4'd7, 1'b0, acc);
      chk("second_accept", acc, 1);
      issue(XOR, 32'h18, 32'hF0F0, 32'h0FF0, 32'd0, 4'd8, 1'b0, acc3);
      chk("full_ready", ALU_ready, 0);
      chk("third_held", acc3, 0);
      for (int i = 0; i < 10 && !acc3; i++)
         issue(XOR, 32'h18, 32'hF0F0, 32'h0FF0, 32'd0, 4'd8, 1'b1, acc3);
      chk("third_accepted", acc3, 1);
      repeat (3) idle(1'b1);

      // Flush with a full FIFO and a simultaneous issue.
      issue(ADD, 32'h20, 32'd2, 32'd3, 32'd0, 4'd9, 1'b0, acc);
      issue(ADD, 32'h24, 32'd4, 32'd5, 32'd0, 4'd10, 1'b0, acc);
      @(negedge clk);
      drive(1'b1, OR, 32'h28, 32'd1, 32'd2, 32'd0, 4'd11, 1'b0, 1'b1, 1'b1, acc);
      @(posedge clk); #2;
      chk("flush_valid", CDB_valid, 0);
      chk("flush_ready", ALU_ready, 1);
      idle(1'b0);
      @(posedge clk); #2;
      chk("flush_op_lost", CDB_valid, 0);

      // Asynchronous reset with one result buffered.
      issue(ADD, 32'h30, 32'd6, 32'd6, 32'd0, 4'd12, 1'b0, acc);
      @(posedge clk); #3;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("async_reset", {CDB_valid, CDB_ROB_id, CDB_value, CDB_is_jump, CDB_target_pc, ALU_ready}, 0);
      @(negedge clk);
      drive(1'b0, 6'd0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
      chk("release_ready", ALU_ready, 1);

      // Randomized traffic with back-pressure, stalls and flushes.
      have = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!have) begin
            op = 6'($urandom_range(1, 37));
            if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(38, 63));
            if ($urandom_range(0, 31) == 0) op = 6'd0;
            pc  = $urandom & 32'hFFFF_FFFC;
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            rob = 4'($urandom);
            have = 1'b1;
         end
         en    = ($urandom_range(0, 3) != 0);
         grant = ($urandom_range(0, 2) != 0);
         r     = ($urandom_range(0, 7) != 0);
         fl    = r && ($urandom_range(0, 24) == 0);
         @(negedge clk);
         drive(en, op, pc, a, b, imm, rob, grant, r, fl, acc);
         if (acc || fl) have = 1'b0;
      end

      repeat (4) idle(1'b1);
      @(posedge clk); #2;
      chk("final_drain", CDB_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port rdy, input, 1 bit: global enable; low freezes all state.
REQ-004 SHALL have port RS_enable, input, 1 bit: the reservation station offers an instruction this cycle.
REQ-005 SHALL have ports RS_OP_ID (input, 6), RS_pc (input, 32), RS_reg_rs1 (input, 32), RS_reg_rs2 (input, 32), RS_imm (input, 32) and RS_ROB_id (input, 4): the operands of the issued instruction.
REQ-006 SHALL have port ALU_ready, output, 1 bit: the unit accepts an issue this cycle.
REQ-007 SHALL have port ROB_flush, input, 1 bit: mispredict flush.
REQ-008 SHALL have port CDB_grant, input, 1 bit: the bus arbiter consumes the head result this cycle.
REQ-009 SHALL have ports CDB_valid (output, 1), CDB_ROB_id (output, 4), CDB_value (output, 32), CDB_is_jump (output, 1) and CDB_target_pc (output, 32): the head result.

Function
REQ-010 An issue SHALL be accepted on a rising edge where rst is high, rdy=1, RS_enable=1, ALU_ready=1 and ROB_flush=0.
REQ-011 An accepted issue SHALL have its result computed combinationally and pushed into a 2-entry result FIFO at that edge; CDB_valid is asserted in the next cycle when the FIFO was empty (1-cycle latency).
REQ-012 ALU_ready SHALL be (count<2) && rdy, with count taken from registered state only; a push into a full FIFO is impossible.
REQ-013 A pop SHALL occur at an edge with CDB_valid=1, CDB_grant=1 and rdy=1; a simultaneous push and pop leaves count unchanged and preserves FIFO order.
REQ-014 CDB_* SHALL always reflect the FIFO head; CDB_valid=(count!=0); CDB outputs hold stable while CDB_grant=0.
REQ-015 Read and write pointers SHALL be 1 bit each, wrapping modulo 2; count SHALL be 2 bits (0..2).
REQ-016 ROB_flush=1 at an edge SHALL clear count and both pointers and discard any same-cycle issue and pop.
REQ-017 rdy=0 SHALL block push and pop; pointers and contents hold; CDB outputs hold.
REQ-018 Arithmetic SHALL be 32-bit wrap-around; shifts use operand[4:0]; SRA/SRAI/SLT/SLTI/BLT/BGE are signed; SLTU/SLTIU/BLTU/BGEU are unsigned.
REQ-019 The immediate forms SHALL use RS_imm as operand 2.
REQ-020 LUI SHALL produce value=imm.
REQ-021 AUIPC SHALL produce value=pc+imm.
REQ-022 JAL SHALL produce value=pc+4, target=pc+imm, is_jump=1.
REQ-023 JALR SHALL produce value=pc+4, target=(rs1+imm)&~1, is_jump=1.
REQ-024 BEQ/BNE/BLT/BGE/BLTU/BGEU SHALL produce value=0, is_jump=taken, target=taken ? pc+imm : pc+4.
REQ-025 Non-jump ops SHALL produce is_jump=0 and target=pc+4.
REQ-026 An undefined OP_ID SHALL produce value=0, is_jump=0, target=pc+4 and still be broadcast, with no hang.

Reset
REQ-027 While rst=0 the unit SHALL immediately force count=0, pointers=0, CDB_valid=0, CDB_ROB_id=0, CDB_value=0, CDB_is_jump=0, CDB_target_pc=0 and ALU_ready=0.
REQ-028 Reset mid-operation SHALL discard all buffered results.
REQ-029 The first issue after reset SHALL be accepted at the first edge where rst is high.

Structure
REQ-030 The shared defines package SHALL hold the OpId encodings (LUI..AND), DataWidth=32, OpIdBus=6, ROBIDBus=4, ImmWidth=32 and True/False.
REQ-031 A purely combinational sub-module alu_core SHALL compute value, is_jump and target from op, pc, rs1, rs2 and imm.
REQ-032 alu_unit SHALL hold only the FIFO and control.

Verification
REQ-033 Issue ADD rs1=5, rs2=7, ROB_id=3 with CDB_grant=1 -> the next cycle shows CDB_valid=1, ROB_id=3, value=12; then CDB_valid=0.
REQ-034 Issue BLT pc=0x100, rs1=0xFFFFFFFF, rs2=1, imm=0x20 -> is_jump=1, target=0x120; the same with BLTU -> is_jump=0, target=0x104.
REQ-035 Hold CDB_grant=0 and issue 3 back-to-back ops -> ALU_ready=0 after 2 accepts; the third is held by the station; granting drains the results in issue order, then the third is accepted.
REQ-036 With count=2, assert ROB_flush together with RS_enable -> the next cycle has CDB_valid=0, count=0 and the issued op is lost.
REQ-037 Pull rst low asynchronously with 1 result buffered -> CDB_valid=0 before the next edge; after release, ALU_ready=1.
REQ-038 Issue JALR pc=0x40, rs1=0x1003, imm=4 -> value=0x44, target=0x1006; SRA rs1=0x80000000, rs2=0x21 -> value=0xC0000000.
